// File: rtl/relu_seq_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : relu_seq_ctrl_if
// Desc     : Source-read / destination-write buffer bus for relu_seq_ctrl.
// Revision : 1.0
//============================================================================
interface relu_seq_ctrl_if #(
  parameter int VEC_SIZE   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                                      rd_en;
  logic [ADDR_WIDTH-1:0]                     rd_addr;
  logic signed [VEC_SIZE-1:0][DATA_WIDTH-1:0] rd_data;
  logic                                      wr_en;
  logic                                      wr_ready;
  logic [ADDR_WIDTH-1:0]                     wr_addr;
  logic signed [VEC_SIZE-1:0][DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data,
    output wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/relu_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module   : relu / relu_seq_ctrl
// Desc     : Lane-wise ReLU, and a sequencer streaming a buffer through it.
// Revision : 1.0
//============================================================================
module relu #(
  parameter int VEC_SIZE   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8
) (
  input  logic signed [VEC_SIZE-1:0][DATA_WIDTH-1:0] x,
  output logic signed [VEC_SIZE-1:0][DATA_WIDTH-1:0] y
);
  // ReLU is independent of the binary point; FIXED_PNT only describes the format.
  if (FIXED_PNT > DATA_WIDTH) begin : g_fxp_wider_than_lane
  end

  for (genvar i = 0; i < VEC_SIZE; i++) begin : g_lane
    assign y[i] = ($signed(x[i]) > 0) ? x[i] : '0;
  end
endmodule

module relu_seq_ctrl #(
  parameter int VEC_SIZE   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic                  bypass,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   vec_cnt,
  relu_seq_ctrl_if.master       bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic                  r_bypass;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_vec_cnt;
  logic                  w_last;
  logic                  w_wr_accept;
  logic                  w_job_start;
  logic signed [VEC_SIZE-1:0][DATA_WIDTH-1:0] w_relu;

  relu #(
    .VEC_SIZE   (VEC_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .FIXED_PNT  (FIXED_PNT)
  ) u_relu (
    .x (bus.rd_data),
    .y (w_relu)
  );

  assign w_job_start = (r_state == IDLE) && start;
  assign w_last      = ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_wr_accept = (r_state == WR) && !abort && bus.wr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? DONE : RD;
        end
      end
      RD: begin
        w_state_nxt = abort ? IDLE : WR;
      end
      WR: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (bus.wr_ready) begin
          w_state_nxt = w_last ? DONE : RD;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_bypass  <= 1'b0;
      r_idx     <= '0;
      r_vec_cnt <= '0;
    end else if (w_job_start) begin
      r_len     <= len;
      r_src     <= src_base;
      r_dst     <= dst_base;
      r_bypass  <= bypass;
      r_idx     <= '0;
      r_vec_cnt <= '0;
    end else if (w_wr_accept) begin
      r_vec_cnt <= r_vec_cnt + 1'b1;
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign vec_cnt = r_vec_cnt;

  // Strobes are dropped in the abort cycle so the memories never see a half-cancelled access.
  assign bus.rd_en   = (r_state == RD) && !abort;
  assign bus.wr_en   = (r_state == WR) && !abort;
  assign bus.rd_addr = r_src + r_idx;
  assign bus.wr_addr = r_dst + r_idx;
  assign bus.wr_data = (r_state == WR) ? (r_bypass ? bus.rd_data : w_relu) : '0;
endmodule
`default_nettype wire

// File: tb/tb_relu_seq_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_relu_seq_ctrl
// Desc     : Scoreboard bench for relu_seq_ctrl with a buffer memory model.
// Revision : 1.0
//============================================================================
module tb_relu_seq_ctrl;
  localparam int VEC_SIZE   = 4;
  localparam int DATA_WIDTH = 16;
  localparam int FIXED_PNT  = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int VW         = VEC_SIZE * DATA_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH:0]   len = '0;
  logic [ADDR_WIDTH-1:0] src_base = '0;
  logic [ADDR_WIDTH-1:0] dst_base = '0;
  logic                  bypass = 1'b0;
  logic                  abort = 1'b0;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   vec_cnt;

  logic ready_force = 1'b1;
  logic rand_mode   = 1'b0;
  logic rnd_bit     = 1'b1;

  relu_seq_ctrl_if #(.VEC_SIZE(VEC_SIZE), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  relu_seq_ctrl #(
    .VEC_SIZE   (VEC_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .FIXED_PNT  (FIXED_PNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .src_base (src_base),
    .dst_base (dst_base),
    .bypass   (bypass),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .vec_cnt  (vec_cnt),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Source buffer model: data appears the cycle after a read and is held.
  logic [VW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end
  assign bus.wr_ready = rand_mode ? rnd_bit : ready_force;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each lane keeps its value if strictly positive, otherwise becomes zero.
  function automatic logic [VW-1:0] ref_relu(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    int            lane;
    r = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      lane = int'($signed(v[i*DATA_WIDTH +: DATA_WIDTH]));
      if (lane > 0) r[i*DATA_WIDTH +: DATA_WIDTH] = v[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  int                    rd_q[$];
  logic [ADDR_WIDTH-1:0] wa_q[$];
  logic [VW-1:0]         wd_q[$];

  task automatic push_exp(input int src, input int dst, input bit byp, input int nrd, input int nwr);
    for (int i = 0; i < nrd; i++) rd_q.push_back((src + i) % DEPTH);
    for (int i = 0; i < nwr; i++) begin
      wa_q.push_back(ADDR_WIDTH'((dst + i) % DEPTH));
      wd_q.push_back(byp ? mem[(src + i) % DEPTH] : ref_relu(mem[(src + i) % DEPTH]));
    end
  endtask

  // Monitor: compares every read strobe and accepted write against the scoreboard.
  logic                  stall_q = 1'b0;
  logic [ADDR_WIDTH-1:0] stall_addr;
  logic [VW-1:0]         stall_data;
  always @(negedge clk) begin
    if (bus.rd_en) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got addr %h expected no read", bus.rd_addr);
      end else begin
        check("rd_addr", 64'(bus.rd_addr), 64'(rd_q.pop_front()));
      end
    end
    if (stall_q && !abort) begin
      check("stall_wr_en", 64'(bus.wr_en), 64'd1);
      check("stall_wr_addr", 64'(bus.wr_addr), 64'(stall_addr));
      check("stall_wr_data", 64'(bus.wr_data), 64'(stall_data));
    end
    if (bus.wr_en && bus.wr_ready) begin
      if (wa_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h expected no write", bus.wr_addr);
      end else begin
        check("wr_addr", 64'(bus.wr_addr), 64'(wa_q.pop_front()));
        check("wr_data", 64'(bus.wr_data), 64'(wd_q.pop_front()));
      end
    end
    stall_q    = bus.wr_en && !bus.wr_ready;
    stall_addr = bus.wr_addr;
    stall_data = bus.wr_data;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_vec_cnt"}, 64'(vec_cnt), 64'd0);
    check({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
  endtask

  // n counts clock edges after the start edge; the current cycle number is n+1.
  task automatic run_job(input int l, input int src, input int dst, input bit byp,
                         input int exp_done, input int exp_cnt, input int stall_at,
                         input int stall_n, input int abort_at, input bit hold_start);
    int n;
    bit fin;
    int limit;
    limit = 8 * l + stall_n + 64;
    @(posedge clk); #1;
    start    = 1'b1;
    len      = (ADDR_WIDTH+1)'(l);
    src_base = ADDR_WIDTH'(src);
    dst_base = ADDR_WIDTH'(dst);
    bypass   = byp;
    @(posedge clk); #1;
    if (hold_start) begin
      len      = (ADDR_WIDTH+1)'(3);
      src_base = ~src_base;
      dst_base = ~dst_base;
      bypass   = ~byp;
    end else begin
      start = 1'b0;
    end
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      ready_force = !(n >= stall_at && n < stall_at + stall_n);
      abort       = (n == abort_at);
      @(negedge clk);
      if (n == abort_at) begin
        check("abort_wr_en", 64'(bus.wr_en), 64'd0);
        check("abort_rd_en", 64'(bus.rd_en), 64'd0);
      end
      if (abort_at >= 0 && n == abort_at + 1) begin
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_vec_cnt", 64'(vec_cnt), 64'(exp_cnt));
        fin = 1'b1;
      end else if (done) begin
        if (exp_done > 0) check("done_cycle", 64'(n + 1), 64'(exp_done));
        check("done_vec_cnt", 64'(vec_cnt), 64'(exp_cnt));
        fin = 1'b1;
      end else if (n >= limit) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    start       = 1'b0;
    abort       = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_vec_cnt", 64'(vec_cnt), 64'(exp_cnt));
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wa_q.size()), 64'd0);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int l, s, d;
    bit b;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sign handling: positive, negative, zero and most-negative lanes.
    mem[8'h10] = {16'h0100, 16'hFF00, 16'h0000, 16'h8000};
    push_exp(8'h10, 8'h20, 1'b0, 1, 1);
    run_job(1, 8'h10, 8'h20, 1'b0, 3, 1, -1, 0, -1, 1'b0);

    // Source address wrap.
    push_exp(8'hFE, 8'h00, 1'b0, 3, 3);
    run_job(3, 8'hFE, 8'h00, 1'b0, 7, 3, -1, 0, -1, 1'b0);

    // Bypass keeps negative lanes.
    mem[8'h40] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    mem[8'h41] = {16'hFFFF, 16'h1234, 16'hFFFF, 16'h8000};
    push_exp(8'h40, 8'h80, 1'b1, 2, 2);
    run_job(2, 8'h40, 8'h80, 1'b1, 5, 2, -1, 0, -1, 1'b0);

    // Backpressure: first write stalled for three cycles.
    push_exp(8'h30, 8'h50, 1'b0, 2, 2);
    run_job(2, 8'h30, 8'h50, 1'b0, 8, 2, 1, 3, -1, 1'b0);

    // Empty job.
    run_job(0, 8'h12, 8'h34, 1'b0, 1, 0, -1, 0, -1, 1'b0);

    // start held through the job and its DONE cycle with altered job inputs.
    push_exp(8'h60, 8'h70, 1'b0, 3, 3);
    run_job(3, 8'h60, 8'h70, 1'b0, 7, 3, -1, 0, -1, 1'b1);

    // Abort during the write of vector 2 of 4.
    push_exp(8'h90, 8'hA0, 1'b0, 2, 1);
    run_job(4, 8'h90, 8'hA0, 1'b0, 0, 1, -1, 0, 3, 1'b0);

    // Whole buffer in one job.
    s = int'($urandom_range(0, DEPTH - 1));
    d = int'($urandom_range(0, DEPTH - 1));
    push_exp(s, d, 1'b0, DEPTH, DEPTH);
    run_job(DEPTH, s, d, 1'b0, 2 * DEPTH + 1, DEPTH, -1, 0, -1, 1'b0);

    // Random jobs with random write backpressure.
    rand_mode = 1'b1;
    for (int j = 0; j < 12; j++) begin
      l = int'($urandom_range(1, 10));
      s = int'($urandom_range(0, DEPTH - 1));
      d = int'($urandom_range(0, DEPTH - 1));
      b = 1'($urandom_range(0, 1));
      push_exp(s, d, b, l, l);
      run_job(l, s, d, b, 0, l, -1, 0, -1, 1'b0);
    end
    rand_mode = 1'b0;

    // Reset in the middle of a job.
    push_exp(8'hC0, 8'hD0, 1'b0, 5, 5);
    @(posedge clk); #1;
    start = 1'b1; len = 9'd5; src_base = 8'hC0; dst_base = 8'hD0; bypass = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midjob_reset");
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/relu_seq_ctrl.md
Name: relu_seq_ctrl

Overview:
- Sequencer that runs a stored vector buffer through the combinational ReLU activation and writes the results to a destination buffer.
- Issues one read per vector word, applies ReLU to all VEC_SIZE lanes, and presents one write with backpressure.
- Sits between the layer output SRAM and the next layer's input SRAM.
- Instantiates the team's relu module internally and has a per-job bypass mode.

Parameters:
VEC_SIZE, 4, lanes per vector word; passed to relu.
DATA_WIDTH, 16, signed lane width; passed to relu.
FIXED_PNT, 8, fractional bits; passed through, not used arithmetically.
ADDR_WIDTH, 8, buffer word-address width.

Ports:
clk  in  1  the only clock.
rst_n  in  1  synchronous reset, active low.
start  in  1  job request; sampled only in IDLE.
len  in  ADDR_WIDTH+1  vector words in job, 0..2^ADDR_WIDTH.
src_base  in  ADDR_WIDTH  first read address.
dst_base  in  ADDR_WIDTH  first write address.
bypass  in  1  1 = copy without ReLU.
abort  in  1  cancel current job.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a job completes.
vec_cnt  out  ADDR_WIDTH+1  vector words written in current/last job.
rd_en  out  1  read strobe.
rd_addr  out  ADDR_WIDTH  read address.
rd_data  in  signed DATA_WIDTH x [VEC_SIZE]  read data; valid the cycle after rd_en, held until the next rd_en.
wr_en  out  1  write request.
wr_ready  in  1  write accepted when wr_en && wr_ready.
wr_addr  out  ADDR_WIDTH  write address.
wr_data  out  signed DATA_WIDTH x [VEC_SIZE]  write data.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state IDLE, idx=0, vec_cnt=0, busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0. Reset mid-job abandons the job with no done pulse.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On start: latch len, src_base, dst_base and bypass into job registers; clear idx and vec_cnt.
  - len!=0 -> RD. len==0 -> DONE, with no reads or writes.
  - Inputs are ignored while busy.
- RD:
  - Drive rd_en=1 and rd_addr=(src_q+idx) mod 2^ADDR_WIDTH for exactly one cycle.
  - Unconditional transition to WR.
- WR:
  - Drive wr_en=1 and wr_addr=(dst_q+idx) mod 2^ADDR_WIDTH.
  - wr_data = bypass_q ? rd_data : relu(rd_data).
  - Per lane, relu gives x when x>0, else 0; most-negative value -> 0; 0 -> 0.
  - Hold all outputs stable while wr_ready=0; no timeout.
  - On acceptance: vec_cnt++. If idx==len_q-1 -> DONE, else idx++ and -> RD.
- DONE: done=1 for one cycle, busy still 1, then -> IDLE. A start in the DONE cycle is ignored.
- Throughput: 2 cycles per vector with wr_ready tied high. Start sampled at edge 0 gives done high in cycle 2*len+1.
- Addresses wrap modulo 2^ADDR_WIDTH. len=2^ADDR_WIDTH covers the whole buffer exactly once.
- abort (any non-IDLE state):
  - Next state is IDLE, no done pulse, vec_cnt keeps its value.
  - wr_en is gated low combinationally in the abort cycle, so no write is accepted that cycle.
  - rd_en is also gated low.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: the job starts.
- vec_cnt holds its final value until the next accepted start.
- Outputs rd_en, wr_en, busy and done are state decodes; address and data are registered or derived from registers plus rd_data.

Test Plan:
- Sign handling, VEC_SIZE=4, DATA_WIDTH=16, len=1, src=0x10, dst=0x20, bypass=0, rd_data={0x0100, 0xFF00, 0x0000, 0x8000}, wr_ready=1:
  - Read at cycle 1 from 0x10.
  - Write at cycle 2 to 0x20 with {0x0100, 0, 0, 0}.
  - done at cycle 3; vec_cnt=1.
- Multi-vector job, len=3, src=0xFE, dst=0x00:
  - Reads 0xFE, 0xFF, 0x00 (wrap).
  - Writes 0x00, 0x01, 0x02 on cycles 2, 4, 6.
  - done at cycle 7.
- Bypass, len=2, bypass=1, negative lanes 0xFFFF: written unchanged as 0xFFFF.
- Backpressure, len=2, wr_ready low for 3 cycles on the first write:
  - wr_en, wr_addr and wr_data stay stable for those 3 cycles.
  - Exactly 2 writes are accepted; done at cycle 8.
- len=0 and ignored starts:
  - start with len=0: done at cycle 1, no rd_en or wr_en.
  - start asserted while busy or during DONE: no effect.
- Abort and reset:
  - abort during the WR of vector 2 of 4: no write that cycle, busy=0 next cycle, no done, vec_cnt=1.
  - rst_n=0 mid-job: all outputs 0 at the next edge.
